// File: rtl/debug_unit_pkg.sv
// Shared constants and state encoding for the UART-side pipeline debug controller.
package debug_unit_pkg;

   localparam logic [7:0]  CMD_LOAD  = 8'h4C;
   localparam logic [7:0]  CMD_CONT  = 8'h43;
   localparam logic [7:0]  CMD_STEP  = 8'h53;
   localparam logic [7:0]  ACK_BYTE  = 8'h06;
   localparam logic [7:0]  NAK_BYTE  = 8'h15;
   localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LOAD_RX,
      ST_LOAD_WR,
      ST_RUN,
      ST_STEP,
      ST_DUMP_SEL,
      ST_DUMP_CAP,
      ST_TX_START,
      ST_TX_WAIT,
      ST_ACK
   } state_t;

endpackage

// File: rtl/debug_tx_serializer.sv
// Sends a word MSB-first as NB_WORD/NB_BYTE bytes (or only its top byte when i_single) over the UART tx strobes.
module debug_tx_serializer #(
   parameter int NB_WORD = 32,
   parameter int NB_BYTE = 8
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic               i_single,
   input  logic [NB_WORD-1:0] i_word,
   input  logic               i_tx_done,
   output logic               o_tx_start,
   output logic [NB_BYTE-1:0] o_tx_data,
   output logic               o_done
);

   localparam int N_BYTES = NB_WORD / NB_BYTE;
   localparam int NB_CNT  = $clog2(N_BYTES + 1);

   logic [NB_WORD-1:0] r_shift;
   logic [NB_CNT-1:0]  r_left;
   logic               r_busy;
   logic               r_go;
   logic               r_done;

   // Handshake: o_tx_start pulses one cycle, o_tx_data holds until i_tx_done;
   // i_tx_done counts only while a byte is in flight (busy and past its start cycle).
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_shift <= '0;
         r_left  <= '0;
         r_busy  <= 1'b0;
         r_go    <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_go   <= 1'b0;
         r_done <= 1'b0;
         if (i_start && !r_busy) begin
            r_shift <= i_word;
            r_left  <= i_single ? NB_CNT'(1) : NB_CNT'(N_BYTES);
            r_busy  <= 1'b1;
            r_go    <= 1'b1;
         end else if (r_busy && !r_go && i_tx_done) begin
            if (r_left == NB_CNT'(1)) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end else begin
               r_shift <= r_shift << NB_BYTE;
               r_left  <= r_left - NB_CNT'(1);
               r_go    <= 1'b1;
            end
         end
      end
   end

   assign o_tx_start = r_go;
   assign o_tx_data  = r_shift[NB_WORD-1 -: NB_BYTE];
   assign o_done     = r_done;

endmodule

// File: rtl/debug_unit.sv
// UART-side debug controller: loads programs into instruction memory, runs or steps
// the pipeline, and dumps registers plus the first data-memory words to the host.
module debug_unit
   import debug_unit_pkg::*;
#(
   parameter int NB_REG     = 32,
   parameter int NB_WIDHT   = 9,
   parameter int NB_BYTE    = 8,
   parameter int N_REGS     = 32,
   parameter int N_MEM_DUMP = 16
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic [NB_BYTE-1:0]  i_rx_data,
   input  logic                i_rx_done,
   input  logic                i_tx_done,
   output logic [NB_BYTE-1:0]  o_tx_data,
   output logic                o_tx_start,
   input  logic                i_halt,
   input  logic [NB_REG-1:0]   i_dunit_reg,
   input  logic [NB_REG-1:0]   i_dunit_mem_data,
   output logic                o_dunit_clk_en,
   output logic                o_dunit_reset_pc,
   output logic                o_dunit_w_mem,
   output logic [NB_WIDHT-1:0] o_dunit_addr,
   output logic [NB_REG-1:0]   o_dunit_data_if,
   output state_t              o_dbg_state
);

   localparam int NB_IDX = $clog2(N_REGS + N_MEM_DUMP);
   localparam logic [NB_IDX-1:0]   IDX_MEM   = NB_IDX'(N_REGS);
   localparam logic [NB_IDX-1:0]   IDX_LAST  = NB_IDX'(N_REGS + N_MEM_DUMP - 1);
   // The address register is one bit wider so the step past the top word is visible.
   localparam logic [NB_WIDHT:0]   ADDR_LAST = (NB_WIDHT+1)'((2**NB_WIDHT) - 4);

   state_t               r_state;
   state_t               w_next;
   logic [NB_WIDHT:0]    r_addr;
   logic [1:0]           r_bcnt;
   logic [NB_REG-1:0]    r_word;
   logic [NB_IDX-1:0]    r_idx;
   logic                 r_single;
   logic [NB_BYTE-1:0]   r_ack;
   logic                 w_ovf;
   logic                 w_clk_en;
   logic                 w_reset_pc;
   logic                 w_w_mem;
   logic                 w_ser_start;
   logic                 w_ser_done;

   function automatic logic [NB_WIDHT:0] f_dump_addr(input logic [NB_IDX-1:0] idx);
      if (idx < IDX_MEM)
         return (NB_WIDHT+1)'(idx);
      return (NB_WIDHT+1)'(idx - IDX_MEM) << 2;
   endfunction

   assign w_ovf = (r_addr > ADDR_LAST);

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= ST_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_clk_en    = 1'b0;
      w_reset_pc  = 1'b0;
      w_w_mem     = 1'b0;
      w_ser_start = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_rx_done) begin
               case (i_rx_data)
                  CMD_LOAD: w_next = ST_LOAD_RX;
                  CMD_CONT: w_next = ST_RUN;
                  CMD_STEP: w_next = ST_STEP;
                  default:  w_next = ST_IDLE;
               endcase
            end
         end
         ST_LOAD_RX: begin
            w_reset_pc = 1'b1;
            if (i_rx_done && r_bcnt == 2'd3) w_next = ST_LOAD_WR;
         end
         ST_LOAD_WR: begin
            w_reset_pc = 1'b1;
            if (w_ovf) begin
               w_next = ST_ACK;
            end else begin
               w_w_mem = 1'b1;
               w_next  = (r_word == HALT_WORD) ? ST_ACK : ST_LOAD_RX;
            end
         end
         ST_RUN: begin
            if (i_halt) w_next   = ST_DUMP_SEL;
            else        w_clk_en = 1'b1;
         end
         ST_STEP: begin
            w_clk_en = 1'b1;
            w_next   = ST_DUMP_SEL;
         end
         ST_DUMP_SEL: w_next = ST_DUMP_CAP;
         ST_DUMP_CAP: w_next = ST_TX_START;
         ST_TX_START: begin
            w_ser_start = 1'b1;
            w_next      = ST_TX_WAIT;
         end
         ST_TX_WAIT: begin
            if (w_ser_done)
               w_next = (r_single || r_idx == IDX_LAST) ? ST_IDLE : ST_DUMP_SEL;
         end
         ST_ACK:  w_next = ST_TX_START;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_addr   <= '0;
         r_bcnt   <= '0;
         r_word   <= '0;
         r_idx    <= '0;
         r_single <= 1'b0;
         r_ack    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_rx_done && w_next != ST_IDLE) begin
                  r_addr   <= '0;
                  r_bcnt   <= '0;
                  r_idx    <= '0;
                  r_single <= 1'b0;
               end
            end
            ST_LOAD_RX: begin
               if (i_rx_done) begin
                  r_word <= {r_word[NB_REG-NB_BYTE-1:0], i_rx_data};
                  r_bcnt <= r_bcnt + 2'd1;
               end
            end
            ST_LOAD_WR: begin
               r_single <= 1'b1;
               r_ack    <= w_ovf ? NB_BYTE'(NAK_BYTE) : NB_BYTE'(ACK_BYTE);
               if (!w_ovf) r_addr <= r_addr + (NB_WIDHT+1)'(4);
            end
            ST_DUMP_CAP: r_word <= (r_idx < IDX_MEM) ? i_dunit_reg : i_dunit_mem_data;
            ST_TX_WAIT: begin
               if (w_ser_done && !r_single) begin
                  r_idx  <= r_idx + NB_IDX'(1);
                  r_addr <= f_dump_addr(r_idx + NB_IDX'(1));
               end
            end
            ST_ACK:  r_word <= {r_ack, {(NB_REG-NB_BYTE){1'b0}}};
            default: ;
         endcase
      end
   end

   debug_tx_serializer #(
      .NB_WORD (NB_REG),
      .NB_BYTE (NB_BYTE)
   ) u_tx_ser (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_start    (w_ser_start),
      .i_single   (r_single),
      .i_word     (r_word),
      .i_tx_done  (i_tx_done),
      .o_tx_start (o_tx_start),
      .o_tx_data  (o_tx_data),
      .o_done     (w_ser_done)
   );

   assign o_dunit_clk_en   = w_clk_en;
   assign o_dunit_reset_pc = w_reset_pc;
   assign o_dunit_w_mem    = w_w_mem;
   assign o_dunit_addr     = r_addr[NB_WIDHT-1:0];
   assign o_dunit_data_if  = w_w_mem ? r_word : '0;
   assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_debug_unit.sv
// Directed bench for debug_unit: load, run, step, dump and load-overflow sequences.
module tb_debug_unit;
  import debug_unit_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [7:0]  i_rx_data;
  logic        i_rx_done;
  logic        i_tx_done;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        i_halt;
  logic [31:0] i_dunit_reg;
  logic [31:0] i_dunit_mem_data;
  logic        o_dunit_clk_en;
  logic        o_dunit_reset_pc;
  logic        o_dunit_w_mem;
  logic [8:0]  o_dunit_addr;
  logic [31:0] o_dunit_data_if;
  state_t      o_dbg_state;

  debug_unit dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_rx_data        (i_rx_data),
    .i_rx_done        (i_rx_done),
    .i_tx_done        (i_tx_done),
    .o_tx_data        (o_tx_data),
    .o_tx_start       (o_tx_start),
    .i_halt           (i_halt),
    .i_dunit_reg      (i_dunit_reg),
    .i_dunit_mem_data (i_dunit_mem_data),
    .o_dunit_clk_en   (o_dunit_clk_en),
    .o_dunit_reset_pc (o_dunit_reset_pc),
    .o_dunit_w_mem    (o_dunit_w_mem),
    .o_dunit_addr     (o_dunit_addr),
    .o_dunit_data_if  (o_dunit_data_if),
    .o_dbg_state      (o_dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 i_clk = ~i_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int tx_delay = 0;
  int halt_after = 7;
  int en_base = 0;
  bit halt_armed = 1'b0;

  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  logic [8:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int en_cnt = 0;
  int overlap_err = 0;
  int stable_err = 0;
  int rp_err = 0;
  int wm_err = 0;
  bit tx_busy = 1'b0;
  bit prev_wmem = 1'b0;
  logic [7:0] tx_hold = '0;

  // ---------------- pipeline readback model ----------------
  function automatic logic [31:0] reg_val(input int i);
    if (i == 1) return 32'h0000_0001;
    return 32'hA500_0000 | 32'(i << 8) | 32'(i);
  endfunction

  function automatic logic [31:0] mem_val(input int a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  assign i_dunit_reg      = reg_val(int'(o_dunit_addr[4:0]));
  assign i_dunit_mem_data = mem_val(int'(o_dunit_addr));

  initial begin
    i_halt = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      i_halt = halt_armed && ((en_cnt - en_base) >= halt_after);
    end
  end

  // UART tx responder: acknowledges each started byte after tx_delay extra cycles
  initial begin
    i_tx_done = 1'b0;
    forever begin
      @(negedge i_clk);
      if (o_tx_start) begin
        repeat (tx_delay) @(posedge i_clk);
        @(posedge i_clk);
        #1 i_tx_done = 1'b1;
        @(posedge i_clk);
        #1 i_tx_done = 1'b0;
      end
    end
  end

  // ---------------- monitor (sampled on the falling edge) ----------------
  always @(negedge i_clk) begin
    if (i_reset) begin
      tx_busy = 1'b0;
    end else begin
      if (o_tx_start) begin
        if (tx_busy) overlap_err++;
        got_q.push_back(o_tx_data);
        tx_hold = o_tx_data;
      end else if (tx_busy && o_tx_data !== tx_hold) begin
        stable_err++;
      end
      if (o_tx_start) tx_busy = 1'b1;
      else if (i_tx_done) tx_busy = 1'b0;
    end
    if (o_dunit_w_mem) begin
      wr_addr_q.push_back(o_dunit_addr);
      wr_data_q.push_back(o_dunit_data_if);
      if (!o_dunit_reset_pc) rp_err++;
      if (prev_wmem) wm_err++;
    end
    prev_wmem = o_dunit_w_mem;
    if (o_dunit_clk_en) en_cnt++;
  end

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(posedge i_clk);
    #1;
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(posedge i_clk);
    #1;
    i_rx_done = 1'b0;
    i_rx_data = '0;
    tick(2);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) send_rx(w[8*b +: 8]);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick(3);
    i_reset = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (o_dbg_state != ST_IDLE && n < budget) begin
      tick(1);
      n++;
    end
    check(name, 32'(o_dbg_state), 32'(ST_IDLE));
  endtask

  task automatic wait_bytes(input int target, input int budget, input string name);
    int n = 0;
    while (got_q.size() < target && n < budget) begin
      tick(1);
      n++;
    end
    check(name, got_q.size(), target);
  endtask

  task automatic check_dump(input int base, input string tag);
    logic [31:0] v;
    exp_q.delete();
    for (int i = 0; i < 32; i++) begin
      v = reg_val(i);
      for (int b = 3; b >= 0; b--) exp_q.push_back(v[8*b +: 8]);
    end
    for (int k = 0; k < 16; k++) begin
      v = mem_val(4 * k);
      for (int b = 3; b >= 0; b--) exp_q.push_back(v[8*b +: 8]);
    end
    for (int j = 0; j < 192; j++)
      check({tag, "_byte"}, 32'(got_q[base + j]), 32'(exp_q.pop_front()));
    check({tag, "_reg1"}, {got_q[base+4], got_q[base+5], got_q[base+6], got_q[base+7]}, 32'h0000_0001);
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic [31:0] word;
    logic [8:0]  exp_addr;
  } load_vec_t;

  typedef struct {
    logic [7:0] rx;
    state_t     exp_state;
  } idle_vec_t;

  load_vec_t load_tbl[3];
  idle_vec_t idle_tbl[4];

  // ---------------- main sequence ----------------
  initial begin
    int wb;
    int gb;
    int eb;
    i_reset   = 1'b1;
    i_rx_data = '0;
    i_rx_done = 1'b0;

    load_tbl[0] = '{32'h2001_0001, 9'd0};
    load_tbl[1] = '{32'h2002_0002, 9'd4};
    load_tbl[2] = '{32'hFFFF_FFFF, 9'd8};
    idle_tbl[0] = '{8'h41, ST_IDLE};
    idle_tbl[1] = '{8'h00, ST_IDLE};
    idle_tbl[2] = '{8'hFF, ST_IDLE};
    idle_tbl[3] = '{8'h6C, ST_IDLE};

    // reset state
    do_reset();
    check("rst_tx_start", o_tx_start, 0);
    check("rst_tx_data", o_tx_data, 0);
    check("rst_clk_en", o_dunit_clk_en, 0);
    check("rst_reset_pc", o_dunit_reset_pc, 0);
    check("rst_w_mem", o_dunit_w_mem, 0);
    check("rst_addr", o_dunit_addr, 0);
    check("rst_data_if", o_dunit_data_if, 0);
    check("rst_state", 32'(o_dbg_state), 32'(ST_IDLE));

    // reset in the middle of a load, then a clean single-word load
    send_rx(CMD_LOAD);
    send_rx(8'h12);
    send_rx(8'h34);
    check("midload_reset_pc", o_dunit_reset_pc, 1);
    i_reset = 1'b1;
    tick(1);
    check("midload_rst_state", 32'(o_dbg_state), 32'(ST_IDLE));
    check("midload_rst_reset_pc", o_dunit_reset_pc, 0);
    check("midload_rst_w_mem", o_dunit_w_mem, 0);
    i_reset = 1'b0;
    wb = wr_addr_q.size();
    send_rx(CMD_LOAD);
    send_word(32'h2001_0001);
    tick(2);
    check("reload_wr_count", wr_addr_q.size() - wb, 1);
    check("reload_wr_addr", wr_addr_q[wb], 0);
    check("reload_wr_data", wr_data_q[wb], 32'h2001_0001);
    do_reset();

    // table-driven load ending in HALT
    wb = wr_addr_q.size();
    gb = got_q.size();
    send_rx(CMD_LOAD);
    check("load_reset_pc", o_dunit_reset_pc, 1);
    for (int i = 0; i < 3; i++) begin
      send_word(load_tbl[i].word);
      check("load_wr_count", wr_addr_q.size() - wb, i + 1);
      check("load_wr_addr", wr_addr_q[wb + i], load_tbl[i].exp_addr);
      check("load_wr_data", wr_data_q[wb + i], load_tbl[i].word);
    end
    wait_bytes(gb + 1, 200, "load_ack_count");
    check("load_ack_byte", got_q[gb], 32'h06);
    wait_idle(50, "load_idle");
    check("load_reset_pc_during_wmem", rp_err, 0);
    check("load_wmem_single_cycle", wm_err, 0);

    // table-driven ignored bytes in IDLE
    for (int i = 0; i < 4; i++) begin
      eb = en_cnt;
      gb = got_q.size();
      send_rx(idle_tbl[i].rx);
      tick(3);
      check("idle_state", 32'(o_dbg_state), 32'(idle_tbl[i].exp_state));
      check("idle_no_clk_en", en_cnt - eb, 0);
      check("idle_no_tx", got_q.size() - gb, 0);
    end

    // continuous run: model halts after 7 enabled cycles
    gb = got_q.size();
    en_base = en_cnt;
    halt_after = 7;
    halt_armed = 1'b1;
    send_rx(CMD_CONT);
    wait_bytes(gb + 192, 5000, "run_dump_count");
    wait_idle(50, "run_idle");
    check("run_clk_en_cycles", en_cnt - en_base, 7);
    check_dump(gb, "run_dump");
    check("run_tx_overlap", overlap_err, 0);

    // single step with slow UART and rx noise during the dump
    tx_delay = 20;
    gb = got_q.size();
    eb = en_cnt;
    send_rx(CMD_STEP);
    tick(30);
    send_rx(CMD_LOAD);
    send_rx(CMD_STEP);
    send_rx(CMD_CONT);
    wait_bytes(gb + 192, 20000, "step_dump_count");
    wait_idle(100, "step_idle");
    tick(10);
    check("step_total_bytes", got_q.size() - gb, 192);
    check("step_clk_en_cycles", en_cnt - eb, 1);
    check_dump(gb, "step_dump");
    check("step_tx_overlap", overlap_err, 0);
    check("step_tx_data_stable", stable_err, 0);

    // load overflow: 129 non-HALT words fit only 128 slots
    tx_delay = 0;
    halt_armed = 1'b0;
    wb = wr_addr_q.size();
    gb = got_q.size();
    send_rx(CMD_LOAD);
    for (int i = 0; i < 129; i++) send_word(32'h1000_0000 | 32'(i));
    wait_bytes(gb + 1, 200, "ovf_nak_count");
    check("ovf_nak_byte", got_q[gb], 32'h15);
    wait_idle(50, "ovf_idle");
    check("ovf_wr_count", wr_addr_q.size() - wb, 128);
    check("ovf_last_addr", wr_addr_q[wb + 127], 9'd508);
    check("ovf_last_data", wr_data_q[wb + 127], 32'h1000_007F);
    tick(5);
    check("ovf_total_bytes", got_q.size() - gb, 1);
    check("ovf_wmem_single_cycle", wm_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
